compressor_feeder: RTL and testbench
====================================

COMPRESSOR_FEEDER -- requirements
Module: compressor_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, input word buffer depth (power of two, 4..64).
REQ-002 SHALL have parameter DATA_ADR, default 3'd0, wishbone word address of the compressor data-input register.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ack watchdog limit (used only under REQ-027).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data  input  32  stream word.
REQ-007 SHALL have port valid  input  1  data qualifier, one word per high cycle, no backpressure.
REQ-008 SHALL have port wb_cyc_o / wb_stb_o / wb_we_o  output  1 each  wishbone master cycle, strobe, write enable.
REQ-009 SHALL have port wb_sel_o  output  4  byte select.
REQ-010 SHALL have port wb_adr_o  output  3  word address (byte address bits 4..2).
REQ-011 SHALL have port wb_dat_o  output  32  write data.
REQ-012 SHALL have port wb_ack_i / wb_err_i  input  1 each  slave acknowledge / error.
REQ-013 SHALL have port count  output  21  words acknowledged by the compressor.
REQ-014 SHALL have port overflow / bus_error  output  1 each  sticky status flags.

Function
REQ-015 SHALL write data into the FIFO on each rising edge with valid=1 and FIFO not full.
REQ-016 SHALL drop the word and set overflow when valid=1 and FIFO full; full is evaluated on pre-edge occupancy, so a pop on the same edge does not admit the push.
REQ-017 SHALL implement FSM states IDLE, WRITE, GAP, HALT.
REQ-018 SHALL move IDLE->WRITE on an edge where the FIFO is non-empty; a word captured at edge T into an empty FIFO drives wb_cyc_o=wb_stb_o=1 from edge T+1.
REQ-019 SHALL, in WRITE, hold wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, wb_adr_o=DATA_ADR, wb_dat_o=FIFO head, all stable until the cycle ends.
REQ-020 SHALL, on an edge with wb_ack_i=1 in WRITE, pop the FIFO, increment count, drop cyc/stb, and go to GAP.
REQ-021 SHALL spend exactly one cycle in GAP with cyc/stb low, then go to WRITE if non-empty, else IDLE (max throughput one word per 2 cycles with zero-wait ack).
REQ-022 SHALL, on an edge with wb_err_i=1 in WRITE (err takes priority over a simultaneous ack), set bus_error, not pop, not count, drop cyc/stb, and go to HALT.
REQ-023 SHALL remain in HALT with no bus activity until reset; FIFO continues accepting input and overflow keeps operating.
REQ-024 SHALL saturate count at 21'h1FFFFF.
REQ-025 SHALL drive wb_cyc_o, wb_stb_o, wb_we_o low and wb_sel_o, wb_adr_o, wb_dat_o to 0 whenever not in WRITE.

Reset
REQ-026 SHALL, on reset_n low (asynchronously, including mid-transaction), force FSM to IDLE, empty the FIFO, clear count, overflow, bus_error and watchdog, and drive all outputs to 0.

Configuration
REQ-027 SHALL compile an ack watchdog when FEEDER_TIMEOUT_EN is defined: a counter cleared on WRITE entry increments each WRITE cycle; at TIMEOUT_CYCLES without ack/err it behaves exactly as REQ-022 (bus_error set, HALT); without the macro there is no watchdog and WRITE waits indefinitely.

Verification
REQ-028 SHALL verify: reset, valid 1 cycle data=32'hDEADBEEF, slave acks in first stb cycle -> stb high edge T+1, dat_o=DEADBEEF, adr_o=DATA_ADR, count=1, next stb no earlier than 2 cycles later.
REQ-029 SHALL verify: 16 consecutive valid words, ack stalled, then 17th word -> overflow=1, 17th dropped; after releasing ack, 16 words emitted in order, count=16.
REQ-030 SHALL verify: wb_err_i and wb_ack_i both high on third transfer -> bus_error=1, count=2, HALT, no further cyc despite 5 queued words.
REQ-031 SHALL verify: reset_n asserted while stb=1 with 3 words queued -> cyc/stb low immediately, after release count=0, no transfer until new valid.
REQ-032 SHALL verify: count preloaded via 2^21+3 acked words (or forced) -> count holds 21'h1FFFFF.
REQ-033 SHALL verify with FEEDER_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never asserted -> cyc drops after 8 WRITE cycles, bus_error=1; without macro stb remains high after 1000 cycles.

Source files
------------

// File: rtl/compressor_feeder.sv
// rtl/compressor_feeder.sv - stream-to-wishbone feeder for the compressor data-input register
//
// Buffers a 32-bit input stream in a small FIFO and writes each word, one
// wishbone single write at a time, to the compressor data register.
// Optional feature macro: FEEDER_TIMEOUT_EN (ack watchdog, TIMEOUT_CYCLES).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   data, valid           input stream word and qualifier (no backpressure)
//   wb_cyc_o/stb_o/we_o   wishbone master cycle, strobe, write enable
//   wb_sel_o, wb_adr_o    byte select, word address
//   wb_dat_o              write data (FIFO head)
//   wb_ack_i, wb_err_i    slave acknowledge / error
//   count                 words acknowledged (saturating)
//   overflow, bus_error   sticky status flags
module compressor_feeder #(
    parameter int         FIFO_DEPTH     = 16,
    parameter logic [2:0] DATA_ADR       = 3'd0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data,
    input  logic        valid,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [20:0] count,
    output logic        overflow,
    output logic        bus_error
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [20:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        bus_error_q, bus_error_d;
    logic        cyc_q, cyc_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic timeout;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full is judged on pre-edge occupancy, so a same-edge pop never admits a push.
    assign push = valid && !fifo_full;
    assign pop  = (state_q == WRITE) && wb_ack_i && !wb_err_i;

`ifdef FEEDER_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;

    assign timeout = (state_q == WRITE) && !wb_ack_i && !wb_err_i &&
                     (wd_q == 32'(TIMEOUT_CYCLES - 1));

    // Cleared whenever WRITE is (re)entered, counts every cycle spent in WRITE.
    always_comb begin
        wd_d = 32'd0;
        if (state_q == WRITE && state_d == WRITE) begin
            wd_d = wd_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q <= 32'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        bus_error_d = bus_error_q;
        overflow_d  = overflow_q | (valid && fifo_full);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Error (or watchdog expiry) wins over a simultaneous ack.
                if (wb_err_i || timeout) begin
                    bus_error_d = 1'b1;
                    state_d     = HALT;
                end else if (wb_ack_i) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (count_q != 21'h1FFFFF) begin
                        count_d = count_q + 21'd1;
                    end
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = fifo_empty ? IDLE : WRITE;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        // Bus outputs are registered from the next state. Whenever WRITE is the
        // next state no pop happens on this edge, so the head is mem[rd_ptr_q].
        cyc_d = (state_d == WRITE);
        sel_d = cyc_d ? 4'hF : 4'h0;
        adr_d = cyc_d ? DATA_ADR : 3'd0;
        dat_d = cyc_d ? mem_q[rd_ptr_q[AW-1:0]] : 32'd0;
    end

    // Storage array needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 21'd0;
            overflow_q  <= 1'b0;
            bus_error_q <= 1'b0;
            cyc_q       <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 3'd0;
            dat_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            bus_error_q <= bus_error_d;
            cyc_q       <= cyc_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = cyc_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_compressor_feeder.sv
// tb/tb_compressor_feeder.sv - directed self-checking bench for compressor_feeder
module tb_compressor_feeder;

    logic        clk;
    logic        reset_n;
    logic [31:0] data;
    logic        valid;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [20:0] count;
    logic        overflow;
    logic        bus_error;

    int tests = 0;
    int fails = 0;

    logic        ack_en = 1'b0;
    int          err_at = -1;
    int          n_acked = 0;
    logic [31:0] log_q [64];

    compressor_feeder #(
        .FIFO_DEPTH     (16),
        .DATA_ADR       (3'd5),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data      (data),
        .valid     (valid),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .count     (count),
        .overflow  (overflow),
        .bus_error (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slave: answers in the first strobe cycle when enabled.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_stb_o && ack_en) begin
            wb_ack_i = 1'b1;
            if (n_acked == err_at) wb_err_i = 1'b1;
        end
    end

    // Record every successfully acknowledged write.
    always @(posedge clk) begin
        if (wb_stb_o && wb_ack_i && !wb_err_i) begin
            log_q[n_acked % 64] = wb_dat_o;
            n_acked = n_acked + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 32'd0;
        ack_en  = 1'b0;
        err_at  = -1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    int  base;
    int  stb_cycles;
    logic seen;

    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;

        // Reset state
        do_reset();
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_count", {11'd0, count}, 32'd0);
        chk("rst_flags", {30'd0, overflow, bus_error}, 32'd0);

        // Single word, zero-wait ack, then a second word to check the gap
        ack_en = 1'b1;
        data = 32'hDEADBEEF; valid = 1'b1;
        tick();                                   // edge T: captured
        chk("t1_stb_T", {31'd0, wb_stb_o}, 32'd0);
        data = 32'h0000_1234;
        tick();                                   // edge T+1
        valid = 1'b0;
        chk("t1_stb_T1", {31'd0, wb_stb_o}, 32'd1);
        chk("t1_cyc_T1", {31'd0, wb_cyc_o}, 32'd1);
        chk("t1_we_T1", {31'd0, wb_we_o}, 32'd1);
        chk("t1_sel", {28'd0, wb_sel_o}, 32'hF);
        chk("t1_adr", {29'd0, wb_adr_o}, 32'd5);
        chk("t1_dat", wb_dat_o, 32'hDEADBEEF);
        tick();                                   // edge T+2: acked
        chk("t1_count1", {11'd0, count}, 32'd1);
        chk("t1_gap_stb", {31'd0, wb_stb_o}, 32'd0);
        tick();                                   // edge T+3: second write
        chk("t1_stb_T3", {31'd0, wb_stb_o}, 32'd1);
        chk("t1_dat2", wb_dat_o, 32'h0000_1234);
        tick();
        chk("t1_count2", {11'd0, count}, 32'd2);
        tick();
        chk("t1_idle_stb", {31'd0, wb_stb_o}, 32'd0);

        // Overflow with ack stalled, then drain in order
        do_reset();
        for (int i = 0; i < 16; i++) begin
            data = 32'h1000_0000 + i; valid = 1'b1;
            tick();
        end
        chk("t2_no_ovf_16", {31'd0, overflow}, 32'd0);
        data = 32'hBAD0_0017;
        tick();
        valid = 1'b0;
        chk("t2_ovf_17", {31'd0, overflow}, 32'd1);
        base = n_acked;
        ack_en = 1'b1;
        for (int i = 0; i < 100 && count != 21'd16; i++) tick();
        repeat (6) tick();
        chk("t2_count16", {11'd0, count}, 32'd16);
        chk("t2_nacked", n_acked - base, 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_order%0d", i), log_q[(base + i) % 64], 32'h1000_0000 + i);
        end
        chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Error on third transfer with simultaneous ack, then HALT
        do_reset();
        ack_en = 1'b1;
        err_at = n_acked + 2;
        for (int i = 0; i < 8; i++) begin
            data = 32'h2000_0000 + i; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        repeat (3) tick();
        chk("t3_bus_error", {31'd0, bus_error}, 32'd1);
        chk("t3_count2", {11'd0, count}, 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | wb_cyc_o;
        end
        chk("t3_no_cyc_halt", {31'd0, seen}, 32'd0);
        // Six words still queued; ten more fill the FIFO, one more overflows
        for (int i = 0; i < 10; i++) begin
            data = 32'h3000_0000 + i; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        chk("t3_halt_no_ovf", {31'd0, overflow}, 32'd0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("t3_halt_ovf", {31'd0, overflow}, 32'd1);
        chk("t3_count_hold", {11'd0, count}, 32'd2);
        err_at = -1;

        // Asynchronous reset in the middle of a transfer
        do_reset();
        for (int i = 0; i < 3; i++) begin
            data = 32'h4000_0000 + i; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        tick();
        chk("t4_stb_before", {31'd0, wb_stb_o}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t4_async_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("t4_async_stb", {31'd0, wb_stb_o}, 32'd0);
        tick();
        reset_n = 1'b1;
        ack_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | wb_stb_o;
        end
        chk("t4_no_xfer", {31'd0, seen}, 32'd0);
        chk("t4_count0", {11'd0, count}, 32'd0);
        data = 32'hCAFEF00D; valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("t4_new_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("t4_new_dat", wb_dat_o, 32'hCAFEF00D);
        tick();
        chk("t4_count1", {11'd0, count}, 32'd1);

        // Count saturation from a preloaded value
        tick();
        force dut.count_q = 21'h1FFFFD;
        tick();
        release dut.count_q;
        #1;
        chk("t5_preload", {11'd0, count}, 32'h1FFFFD);
        base = n_acked;
        for (int i = 0; i < 3; i++) begin
            data = 32'h5000_0000 + i; valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        repeat (10) tick();
        chk("t5_nacked", n_acked - base, 32'd3);
        chk("t5_saturated", {11'd0, count}, 32'h1FFFFF);

        // Ack never arrives
        do_reset();
        data = 32'h6000_0001; valid = 1'b1;
        tick();
        valid = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
        stb_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wb_stb_o) stb_cycles++;
        end
        chk("t6_wd_cycles", stb_cycles, 32'd8);
        chk("t6_wd_bus_error", {31'd0, bus_error}, 32'd1);
`else
        repeat (1000) tick();
        chk("t6_stb_held", {31'd0, wb_stb_o}, 32'd1);
        chk("t6_no_bus_error", {31'd0, bus_error}, 32'd0);
        chk("t6_dat_held", wb_dat_o, 32'h6000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
